prim_clock_div_inv: RTL
=======================

PRIM_CLOCK_DIV_INV -- requirements
Module: prim_clock_div_inv

Interface
REQ-001 SHALL have parameter DivWidth, default 8, width of divide-ratio field.
REQ-002 SHALL have parameter ResetDiv, default 2, divide ratio active out of reset (legal range 2..2^DivWidth-1).
REQ-003 SHALL have parameter HasScanMode, default 1'b1; when 0, scanmode_i is ignored and treated as 0.
REQ-004 SHALL have port clk_i  input  1  single source clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port scanmode_i  input  1  DFT bypass: clk_o follows clk_i.
REQ-007 SHALL have port div_i  input  DivWidth  requested divide ratio N.
REQ-008 SHALL have port invert_i  input  1  requested output polarity (1 = inverted).
REQ-009 SHALL have port req_i  input  1  single-cycle request to load div_i/invert_i.
REQ-010 SHALL have port ack_o  output  1  one-cycle pulse when requested settings take effect.
REQ-011 SHALL have port busy_o  output  1  high while a request is pending.
REQ-012 SHALL have port clk_o  output  1  divided, optionally inverted clock.

Function
REQ-013 SHALL hold active ratio div_q, active polarity inv_q, period counter cnt_q (DivWidth bits), divided-phase register ph_q.
REQ-014 SHALL treat any N < 2 (on div_i or ResetDiv) as N = 2.
REQ-015 SHALL count cnt_q 0..div_q-1 and wrap to 0; cycle with cnt_q == div_q-1 is the period boundary.
REQ-016 SHALL drive ph_q = 1 for cnt_q in [0, div_q/2) (integer division) and 0 otherwise, registered; period = div_q clk_i cycles; duty 50% for even N, high phase one cycle shorter for odd N.
REQ-017 SHALL drive clk_o = clk_i when scanmode_i=1 and HasScanMode=1, else clk_o = ph_q XOR inv_q; the select SHALL be the only combinational path from clk_i to clk_o.
REQ-018 SHALL implement FSM with states RUN and PEND; busy_o = (state == PEND).
REQ-019 RUN: req_i=1 SHALL capture div_i/invert_i into pending registers and go to PEND next cycle.
REQ-020 PEND: req_i=1 SHALL overwrite pending registers (latest wins); only one ack_o results.
REQ-021 PEND at period boundary SHALL load div_q/inv_q from pending, reset cnt_q to 0, pulse ack_o in the following cycle, return to RUN; no runt or truncated clk_o period SHALL occur.
REQ-022 req_i in the same cycle as a PEND boundary SHALL be taken as a new request: the old pending value is applied, the new one captured, state stays PEND, ack_o pulses once for the applied value.
REQ-023 While scanmode_i=1, cnt_q, ph_q, FSM SHALL freeze; pending requests SHALL remain pending and req_i SHALL be ignored.
REQ-024 Inversion change SHALL take effect only at period boundary, producing no glitch narrower than one clk_i cycle.

Reset
REQ-025 On rst_i=1, asynchronously: cnt_q=0, ph_q=0, div_q=max(ResetDiv,2), inv_q=0, state=RUN, ack_o=0, busy_o=0; clk_o=0 (scanmode_i=0).
REQ-026 Reset mid-request SHALL discard the pending request without ack_o.
REQ-027 After rst_i deasserts, first clk_i rising edge SHALL start counting; clk_o rises on the first edge after cnt_q=0 is registered.

Verification
REQ-028 Reset release, ResetDiv=2, no requests -> clk_o toggles every clk_i cycle, period 2, ack_o=0, busy_o=0.
REQ-029 req_i with div_i=5 mid-period of N=4 -> busy_o=1 until boundary, then period 5 with 2 high / 3 low cycles, one ack_o pulse, no short pulse.
REQ-030 req_i div_i=6 then div_i=3 two cycles later, both before boundary -> single ack_o, final period 3.
REQ-031 req_i invert_i=1 with N=4 -> clk_o polarity flips exactly at next boundary, minimum pulse width >= 2 clk_i cycles.
REQ-032 scanmode_i=1 for 10 cycles with request pending -> clk_o equals clk_i, counter frozen, busy_o stays 1; after release, request applies at next boundary.
REQ-033 rst_i asserted while busy_o=1, div_i=0 requested earlier -> all outputs at reset values immediately, no ack_o, ratio returns to ResetDiv.

Source files
------------

// File: rtl/prim_clock_div_inv.sv
// prim_clock_div_inv
// Divides clk_i by a run-time programmable ratio N (>= 2) and can invert the
// result. New ratio/polarity requests are held pending and applied only at a
// period boundary, so clk_o never shows a runt or truncated period. A DFT
// scan mode routes clk_i straight to clk_o and freezes all state.
module prim_clock_div_inv #(
    parameter int unsigned DivWidth    = 8,
    parameter int unsigned ResetDiv    = 2,
    parameter bit          HasScanMode = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                scanmode_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                invert_i,
    input  logic                req_i,
    output logic                ack_o,
    output logic                busy_o,
    output logic                clk_o
);

    // Ratios below 2 cannot form a high and a low phase, so they saturate to 2.
    function automatic logic [DivWidth-1:0] sat_div(input logic [DivWidth-1:0] n);
        return (n < DivWidth'(2)) ? DivWidth'(2) : n;
    endfunction

    localparam logic [DivWidth-1:0] RESET_DIV =
        (ResetDiv < 2) ? DivWidth'(2) : DivWidth'(ResetDiv);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic                inv_q, inv_d;
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic                ph_q, ph_d;
    // Polarity that belongs to the counter value ph_q was computed from; it
    // lags inv_q by one cycle exactly as ph_q lags cnt_q, so a polarity change
    // lines up with the first phase cycle of the new period.
    logic                inv_ph_q, inv_ph_d;
    logic                ack_q, ack_d;
    logic [DivWidth-1:0] pend_div_q, pend_div_d;
    logic                pend_inv_q, pend_inv_d;

    logic                scan_en;
    logic                boundary;
    logic                capture;

    assign scan_en  = HasScanMode && scanmode_i;
    assign boundary = (cnt_q == (div_q - DivWidth'(1)));
    // Requests are ignored entirely while the divider is frozen for scan.
    assign capture  = req_i && !scan_en;

    // Period counter and registered phase; both hold still during scan.
    always_comb begin
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        inv_ph_d = inv_ph_q;
        if (!scan_en) begin
            ph_d     = (cnt_q < (div_q >> 1));
            inv_ph_d = inv_q;
            cnt_d    = boundary ? '0 : (cnt_q + DivWidth'(1));
        end
    end

    // Request FSM: RUN waits for a request, PEND applies it at the boundary.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        inv_d      = inv_q;
        ack_d      = 1'b0;
        pend_div_d = pend_div_q;
        pend_inv_d = pend_inv_q;
        if (!scan_en) begin
            unique case (state_q)
                RUN: begin
                    if (capture) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        div_d   = pend_div_q;
                        inv_d   = pend_inv_q;
                        ack_d   = 1'b1;
                        state_d = RUN;
                    end
                    // A request coinciding with the boundary is a fresh
                    // request: the old one was just applied above.
                    if (capture) begin
                        state_d = PEND;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        if (capture) begin
            pend_div_d = sat_div(div_i);
            pend_inv_d = invert_i;
        end
    end

    // Control and active-setting registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            div_q    <= RESET_DIV;
            inv_q    <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= 1'b0;
            inv_ph_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            inv_q    <= inv_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            inv_ph_q <= inv_ph_d;
            ack_q    <= ack_d;
        end
    end

    // Pending settings are only consumed in PEND, so they need no reset.
    always_ff @(posedge clk_i) begin
        pend_div_q <= pend_div_d;
        pend_inv_q <= pend_inv_d;
    end

    assign ack_o  = ack_q;
    assign busy_o = (state_q == PEND);
    // The scan select is the only combinational path from clk_i to clk_o.
    assign clk_o  = scan_en ? clk_i : (ph_q ^ inv_ph_q);

endmodule
